cpu_ctrl_seq: RTL and testbench

- Multi-cycle control sequencer for the RV32I core.
- Consumes the decoder's one-hot instr_type and qualifier flags.
- Sequences fetch/decode/execute/memory/writeback over one shared memory port with a req/ack handshake.
- Drives the write enables and mux selects of the PC, IR, register file and ALU. Halts on system instructions, illegal decode or memory timeout.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/mem_wait_timer.sv | 41 ++++
 rtl/cpu_ctrl_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I multi-cycle control path: sequencer
// states, one-hot instruction-class bit positions and mux/cause encodings.
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_e;

   // Bit positions inside the decoder's one-hot instr_type (MSB..LSB: J U B S I R)
   localparam int IDX_J = 5;
   localparam int IDX_U = 4;
   localparam int IDX_B = 3;
   localparam int IDX_S = 2;
   localparam int IDX_I = 1;
   localparam int IDX_R = 0;

   // PC source select
   localparam logic [1:0] PC_SEL_PC4 = 2'b00;
   localparam logic [1:0] PC_SEL_IMM = 2'b01;
   localparam logic [1:0] PC_SEL_ALU = 2'b10;

   // Register-file write-back source select
   localparam logic [1:0] WB_SEL_ALU = 2'b00;
   localparam logic [1:0] WB_SEL_MEM = 2'b01;
   localparam logic [1:0] WB_SEL_PC4 = 2'b10;
   localparam logic [1:0] WB_SEL_IMM = 2'b11;

   // Reason the core halted
   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_SYSTEM  = 2'b01;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle watchdog for a req/ack memory handshake. Counts cycles spent
// waiting for an acknowledge and flags a timeout once MEM_TIMEOUT waits have
// elapsed with no acknowledge in the current cycle (a late ack still wins).
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   input  logic ack,
   output logic timeout
);

   localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

   logic [7:0] count_r;

   // Count un-acknowledged request cycles; restart whenever idle or acknowledged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= 8'd0;
      end else if (clear || ack) begin
         count_r <= 8'd0;
      end else if (en && (count_r != LIMIT)) begin
         count_r <= count_r + 8'd1;
      end else begin
         count_r <= count_r;
      end
   end

   // Timeout fires only in a cycle that reached the limit without an ack.
   always_comb begin
      if (en && !clear && !ack && (count_r == LIMIT)) begin
         timeout = 1'b1;
      end else begin
         timeout = 1'b0;
      end
   end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer for the RV32I core. Walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB over a single shared memory port and
// drives the PC, IR, register-file and ALU controls. System instructions,
// illegal decodes and memory timeouts park the core in TRAP until reset.
module cpu_ctrl_seq
   import cpu_pkg::*;
#(
   parameter int INSTR_TYPES = 6,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INSTR_TYPES-1:0] instr_type,
   input  logic                   is_load,
   input  logic                   is_jalr,
   input  logic                   is_lui,
   input  logic                   is_system,
   input  logic                   branch_taken,
   input  logic                   mem_ack,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic                   addr_sel,
   output logic                   ir_we,
   output logic                   alu_en,
   output logic                   rf_we,
   output logic [1:0]             wb_sel,
   output logic                   pc_we,
   output logic [1:0]             pc_sel,
   output logic                   trap,
   output logic [1:0]             trap_cause,
   output logic [CNT_W-1:0]       retired
);

   state_e                 state_r;
   state_e                 state_next_s;
   logic [1:0]             cause_r;
   logic [1:0]             cause_next_s;
   logic [CNT_W-1:0]       retired_r;
   logic [INSTR_TYPES-1:0] type_dec_s;
   logic                   type_onehot_s;
   logic                   is_store_s;
   logic                   is_load_op_s;
   logic                   req_active_s;
   logic                   timer_clear_s;
   logic                   timeout_s;

   // A value is one-hot when non-zero and clearing its lowest set bit leaves zero.
   assign type_dec_s    = instr_type - {{(INSTR_TYPES-1){1'b0}}, 1'b1};
   assign type_onehot_s = (instr_type != {INSTR_TYPES{1'b0}}) &&
                          ((instr_type & type_dec_s) == {INSTR_TYPES{1'b0}});

   assign is_store_s    = instr_type[IDX_S];
   assign is_load_op_s  = instr_type[IDX_I] & is_load;

   // The wait timer only runs while a memory request is outstanding.
   assign req_active_s  = (state_r == ST_FETCH) || (state_r == ST_MEM);
   assign timer_clear_s = !req_active_s;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear_s),
      .en      (req_active_s),
      .ack     (mem_ack),
      .timeout (timeout_s)
   );

   // State register; reset abandons any outstanding request and restarts at FETCH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_FETCH;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state and trap-cause selection.
   always_comb begin
      state_next_s = state_r;
      cause_next_s = cause_r;
      case (state_r)
         ST_FETCH: begin
            if (mem_ack) begin
               state_next_s = ST_DECODE;
            end else if (timeout_s) begin
               state_next_s = ST_TRAP;
               cause_next_s = CAUSE_TIMEOUT;
            end else begin
               state_next_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            if (!type_onehot_s) begin
               state_next_s = ST_TRAP;
               cause_next_s = CAUSE_ILLEGAL;
            end else if (is_system) begin
               state_next_s = ST_TRAP;
               cause_next_s = CAUSE_SYSTEM;
            end else begin
               state_next_s = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (instr_type[IDX_B]) begin
               state_next_s = ST_FETCH;
            end else if (is_store_s || is_load_op_s) begin
               state_next_s = ST_MEM;
            end else begin
               state_next_s = ST_WB;
            end
         end
         ST_MEM: begin
            if (mem_ack) begin
               state_next_s = is_store_s ? ST_FETCH : ST_WB;
            end else if (timeout_s) begin
               state_next_s = ST_TRAP;
               cause_next_s = CAUSE_TIMEOUT;
            end else begin
               state_next_s = ST_MEM;
            end
         end
         ST_WB: begin
            state_next_s = ST_FETCH;
         end
         ST_TRAP: begin
            state_next_s = ST_TRAP;
         end
         default: begin
            state_next_s = ST_FETCH;
         end
      endcase
   end

   // Datapath controls: Moore per state plus single-cycle Mealy write pulses.
   always_comb begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      ir_we    = 1'b0;
      alu_en   = 1'b0;
      rf_we    = 1'b0;
      wb_sel   = WB_SEL_ALU;
      pc_we    = 1'b0;
      pc_sel   = PC_SEL_PC4;
      trap     = 1'b0;
      case (state_r)
         ST_FETCH: begin
            mem_req = 1'b1;
            ir_we   = mem_ack;
         end
         ST_DECODE: begin
            alu_en = 1'b0;
         end
         ST_EXEC: begin
            alu_en = 1'b1;
            if (instr_type[IDX_B]) begin
               pc_we  = 1'b1;
               pc_sel = branch_taken ? PC_SEL_IMM : PC_SEL_PC4;
            end else begin
               pc_we  = 1'b0;
            end
         end
         ST_MEM: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = is_store_s;
            if (mem_ack && is_store_s) begin
               pc_we = 1'b1;
            end else begin
               pc_we = 1'b0;
            end
         end
         ST_WB: begin
            rf_we = 1'b1;
            pc_we = 1'b1;
            if (instr_type[IDX_J]) begin
               wb_sel = WB_SEL_PC4;
               pc_sel = PC_SEL_IMM;
            end else if (instr_type[IDX_U]) begin
               wb_sel = is_lui ? WB_SEL_IMM : WB_SEL_ALU;
            end else if (instr_type[IDX_I] && is_load) begin
               wb_sel = WB_SEL_MEM;
            end else if (instr_type[IDX_I] && is_jalr) begin
               wb_sel = WB_SEL_PC4;
               pc_sel = PC_SEL_ALU;
            end else begin
               wb_sel = WB_SEL_ALU;
            end
         end
         ST_TRAP: begin
            trap = 1'b1;
         end
         default: begin
            trap = 1'b0;
         end
      endcase
   end

   // Latch the halt reason on entry to TRAP; held until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cause_r <= CAUSE_NONE;
      end else begin
         cause_r <= cause_next_s;
      end
   end

   // Retired-instruction counter: one count per PC update, wrapping naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired_r <= {CNT_W{1'b0}};
      end else if (pc_we) begin
         retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         retired_r <= retired_r;
      end
   end

   assign trap_cause = cause_r;
   assign retired    = retired_r;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Scoreboard bench for cpu_ctrl_seq. The stimulus side plays decoder and
// memory, predicts each instruction's outcome from the architectural rules
// (latency, selects, trap cause, retire count) and queues it; a monitor pops
// and compares whenever the DUT retires (pc_we) or enters trap.
module tb_cpu_ctrl_seq;

   localparam int MT = 15;

   localparam int OP_R     = 0;
   localparam int OP_IALU  = 1;
   localparam int OP_LOAD  = 2;
   localparam int OP_JALR  = 3;
   localparam int OP_S     = 4;
   localparam int OP_B     = 5;
   localparam int OP_J     = 6;
   localparam int OP_LUI   = 7;
   localparam int OP_AUIPC = 8;
   localparam int OP_SYS   = 9;
   localparam int OP_ILL   = 10;

   typedef struct {
      bit          is_trap;
      int          cycles;
      logic [1:0]  pc_sel;
      logic [1:0]  wb_sel;
      logic [1:0]  cause;
      bit          rf_we;
      bit          store;
      int          ir_n;
      logic [31:0] retired;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  instr_type;
   logic        is_load, is_jalr, is_lui, is_system, branch_taken, mem_ack;
   logic        mem_req, mem_we, addr_sel, ir_we, alu_en, rf_we, pc_we, trap;
   logic [1:0]  wb_sel, pc_sel, trap_cause;
   logic [31:0] retired;

   int          checks = 0;
   int          errors = 0;
   int          fetch_wait = 0;
   int          mem_wait = 0;
   logic [31:0] model_retired = 32'd0;
   exp_t        sb[$];

   cpu_ctrl_seq #(.INSTR_TYPES(6), .MEM_TIMEOUT(MT), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .instr_type(instr_type), .is_load(is_load),
      .is_jalr(is_jalr), .is_lui(is_lui), .is_system(is_system),
      .branch_taken(branch_taken), .mem_ack(mem_ack), .mem_req(mem_req),
      .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we), .alu_en(alu_en),
      .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
      .trap(trap), .trap_cause(trap_cause), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural outcome of one instruction given its wait profile.
   function automatic exp_t model(input int op, input int fw, input int mw,
                                  input bit taken, input logic [31:0] ret);
      exp_t e;
      int   c;
      e.is_trap = 1'b0; e.cycles = 0; e.pc_sel = 2'b00; e.wb_sel = 2'b00;
      e.cause = 2'b00; e.rf_we = 1'b0; e.store = (op == OP_S); e.ir_n = 1;
      e.retired = ret;
      if (fw > MT) begin
         e.is_trap = 1'b1; e.cause = 2'b11; e.cycles = MT + 2; e.ir_n = 0;
         return e;
      end
      c = fw + 2;
      if (op == OP_ILL || op == OP_SYS) begin
         e.is_trap = 1'b1; e.cause = (op == OP_ILL) ? 2'b10 : 2'b01; e.cycles = c + 1;
         return e;
      end
      c = c + 1;
      if (op == OP_B) begin
         e.pc_sel = taken ? 2'b01 : 2'b00; e.cycles = c;
         return e;
      end
      if (op == OP_S || op == OP_LOAD) begin
         if (mw > MT) begin
            e.is_trap = 1'b1; e.cause = 2'b11; e.cycles = c + MT + 2;
            return e;
         end
         c = c + mw + 1;
         if (op == OP_S) begin
            e.cycles = c;
            return e;
         end
      end
      e.cycles = c + 1;
      e.rf_we  = 1'b1;
      case (op)
         OP_LOAD: e.wb_sel = 2'b01;
         OP_JALR: begin e.wb_sel = 2'b10; e.pc_sel = 2'b10; end
         OP_J:    begin e.wb_sel = 2'b10; e.pc_sel = 2'b01; end
         OP_LUI:  e.wb_sel = 2'b11;
         default: e.wb_sel = 2'b00;
      endcase
      return e;
   endfunction

   task automatic reset_seq();
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rst_trap", 32'(trap), 32'd0);
      chk("rst_retired", retired, 32'd0);
      chk("rst_cause", 32'(trap_cause), 32'd0);
      @(negedge clk); #2;
      chk("rst_mem_req", 32'(mem_req), 32'd1);
      chk("rst_outputs", 32'({ir_we, rf_we, pc_we, alu_en, addr_sel, mem_we, wb_sel, pc_sel}), 32'd0);
      sb.delete();
      model_retired = 32'd0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic do_instr(input int op, input int fw, input int mw, input bit taken,
                           input logic [5:0] ill_v);
      exp_t e;
      bit   done;
      instr_type   = 6'b000000;
      is_load      = 1'($urandom_range(0, 1));
      is_jalr      = 1'($urandom_range(0, 1));
      is_lui       = 1'($urandom_range(0, 1));
      is_system    = 1'b0;
      branch_taken = taken;
      case (op)
         OP_R:     instr_type = 6'b000001;
         OP_IALU:  begin instr_type = 6'b000010; is_load = 1'b0; is_jalr = 1'b0; end
         OP_LOAD:  begin instr_type = 6'b000010; is_load = 1'b1; is_jalr = 1'b0; end
         OP_JALR:  begin instr_type = 6'b000010; is_load = 1'b0; is_jalr = 1'b1; end
         OP_S:     instr_type = 6'b000100;
         OP_B:     instr_type = 6'b001000;
         OP_J:     instr_type = 6'b100000;
         OP_LUI:   begin instr_type = 6'b010000; is_lui = 1'b1; end
         OP_AUIPC: begin instr_type = 6'b010000; is_lui = 1'b0; end
         OP_SYS:   begin instr_type = 6'b000010; is_load = 1'b0; is_jalr = 1'b0; is_system = 1'b1; end
         default:  begin instr_type = ill_v; is_system = 1'($urandom_range(0, 1)); end
      endcase
      fetch_wait = fw;
      mem_wait   = mw;
      e = model(op, fw, mw, taken, model_retired);
      sb.push_back(e);
      if (!e.is_trap) model_retired = model_retired + 32'd1;
      done = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk); #2;
         if (pc_we || trap) done = 1'b1;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL event_wait: actual no pc_we/trap, required one within 400 cycles (op %0d)", op);
         reset_seq();
      end else if (trap) begin
         if (e.is_trap) begin
            for (int k = 0; k < 3; k++) begin
               @(negedge clk); #2;
               chk("trap_held", 32'(trap), 32'd1);
               chk("cause_held", 32'(trap_cause), 32'(e.cause));
               chk("trap_quiet", 32'({mem_req, pc_we, rf_we, ir_we, alu_en}), 32'd0);
            end
         end
         reset_seq();
      end else begin
         @(posedge clk); #1;
      end
   endtask

   task automatic abort_mid_mem();
      bit in_mem;
      instr_type = 6'b000010; is_load = 1'b1; is_jalr = 1'b0; is_system = 1'b0;
      fetch_wait = 0; mem_wait = 255;
      in_mem = 1'b0;
      for (int c = 0; c < 20 && !in_mem; c++) begin
         @(negedge clk); #2;
         if (addr_sel) in_mem = 1'b1;
      end
      chk("abort_reached_mem", 32'(in_mem), 32'd1);
      @(negedge clk); #2;
      chk("abort_retired_before", retired, model_retired);
      chk("abort_mem_req", 32'(mem_req), 32'd1);
      reset_seq();
   endtask

   // Memory responder: acks after the requested number of waits; random
   // acks while no request is outstanding must be ignored by the DUT.
   initial begin
      int req_cnt;
      int target;
      mem_ack = 1'b0;
      req_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mem_ack = 1'b0; req_cnt = 0;
         end else if (!mem_req) begin
            mem_ack = 1'($urandom_range(0, 1)); req_cnt = 0;
         end else begin
            target = addr_sel ? mem_wait : fetch_wait;
            if (req_cnt == target) begin
               mem_ack = 1'b1; req_cnt = 0;
            end else begin
               mem_ack = 1'b0; req_cnt++;
            end
         end
      end
   end

   // Monitor: per-cycle sanity plus scoreboard compare on retire/trap events.
   initial begin
      exp_t e;
      int   cyc, last, ir_cnt;
      bit   trap_prev;
      cyc = 0; last = 0; ir_cnt = 0; trap_prev = 1'b0;
      forever begin
         @(negedge clk); #2;
         if (rst) begin
            cyc = 0; last = 0; ir_cnt = 0; trap_prev = 1'b0;
         end else begin
            cyc++;
            if (ir_we) ir_cnt++;
            if (rf_we && !pc_we) chk("rf_we_alone", 32'(rf_we), 32'd0);
            if (!mem_req) chk("mem_we_no_req", 32'(mem_we), 32'd0);
            if (addr_sel && !trap && sb.size() > 0) begin
               chk("mem_phase_req", 32'(mem_req), 32'd1);
               chk("mem_phase_we", 32'(mem_we), 32'(sb[0].store));
            end
            if (pc_we || (trap && !trap_prev)) begin
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_event: actual pc_we=%0b trap=%0b, required no event", pc_we, trap);
               end else begin
                  e = sb.pop_front();
                  chk("event_kind_trap", 32'(trap), 32'(e.is_trap));
                  chk("latency", 32'(cyc - last), 32'(e.cycles));
                  chk("retired", retired, e.retired);
                  chk("ir_we_count", 32'(ir_cnt), 32'(e.ir_n));
                  if (e.is_trap) begin
                     chk("trap_cause", 32'(trap_cause), 32'(e.cause));
                  end else begin
                     chk("pc_sel", 32'(pc_sel), 32'(e.pc_sel));
                     chk("rf_we", 32'(rf_we), 32'(e.rf_we));
                     if (e.rf_we) chk("wb_sel", 32'(wb_sel), 32'(e.wb_sel));
                  end
               end
               last = cyc; ir_cnt = 0;
            end
            trap_prev = trap;
         end
      end
   end

   initial begin
      int op, fw, mw;
      logic [5:0] ill_v;
      rst = 1'b1; instr_type = 6'b000000; is_load = 1'b0; is_jalr = 1'b0;
      is_lui = 1'b0; is_system = 1'b0; branch_taken = 1'b0;
      repeat (2) @(posedge clk);
      reset_seq();
      // Directed scenarios
      do_instr(OP_R,     0, 0,   1'b0, 6'd0);
      do_instr(OP_LOAD,  1, 3,   1'b0, 6'd0);
      do_instr(OP_B,     0, 0,   1'b1, 6'd0);
      do_instr(OP_B,     2, 0,   1'b0, 6'd0);
      do_instr(OP_J,     0, 0,   1'b0, 6'd0);
      do_instr(OP_JALR,  0, 0,   1'b0, 6'd0);
      do_instr(OP_LUI,   1, 0,   1'b0, 6'd0);
      do_instr(OP_AUIPC, 0, 0,   1'b0, 6'd0);
      do_instr(OP_IALU,  0, 0,   1'b0, 6'd0);
      do_instr(OP_S,     0, MT,  1'b0, 6'd0);
      do_instr(OP_LOAD,  MT, 2,  1'b0, 6'd0);
      do_instr(OP_S,     0, 255, 1'b0, 6'd0);
      do_instr(OP_ILL,   0, 0,   1'b0, 6'b000000);
      do_instr(OP_ILL,   1, 0,   1'b0, 6'b000011);
      do_instr(OP_SYS,   0, 0,   1'b0, 6'd0);
      do_instr(OP_R,     255, 0, 1'b0, 6'd0);
      do_instr(OP_R,     0, 0,   1'b0, 6'd0);
      do_instr(OP_S,     1, 1,   1'b0, 6'd0);
      abort_mid_mem();
      // Randomized stream
      for (int n = 0; n < 150; n++) begin
         op = $urandom_range(0, 10);
         if (op >= OP_SYS && $urandom_range(0, 3) != 0) op = $urandom_range(0, 8);
         fw = ($urandom_range(0, 19) == 0) ? $urandom_range(MT - 1, MT + 2) : $urandom_range(0, 3);
         mw = ($urandom_range(0, 9) == 0)  ? $urandom_range(MT - 1, MT + 2) : $urandom_range(0, 3);
         ill_v = 6'b000000;
         for (int k = 0; k < 50; k++) begin
            if ($countones(ill_v) == 1 || k == 0) ill_v = 6'($urandom_range(0, 63));
         end
         if ($countones(ill_v) == 1) ill_v = 6'b000000;
         do_instr(op, fw, mw, 1'($urandom_range(0, 1)), ill_v);
      end
      repeat (4) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
